// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state and result-flag types for multicycle_adder.
package adder_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;
endpackage

// File: rtl/slice_adder.sv
// slice_adder: combinational SLICE-bit adder exposing carry-out and the carry into its MSB.
module slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
    assign cmsb = s[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: adds/subtracts WIDTH-bit operands SLICE bits per cycle, LSB slice first.
// Subtract support is enabled by defining MULTICYCLE_ADDER_SUB_EN.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] bus_a_i,
    input  logic [WIDTH-1:0] bus_b_i,
    input  logic             carry_i,
    input  logic             op_sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] bus_o,
    output logic             flag_c_o,
    output logic             flag_v_o,
    output logic             flag_z_o,
    output logic             flag_n_o
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, sum_q, nxt_sum;
    logic             carry_q;
    flags_t           flags_q;
    logic [SLICE-1:0] s;
    logic             cout, cmsb, sub_en;

`ifdef MULTICYCLE_ADDER_SUB_EN
    assign sub_en = op_sub_i;
`else
    logic unused_sub;
    assign unused_sub = op_sub_i;
    assign sub_en = 1'b0;
`endif

    slice_adder #(.SLICE(SLICE)) u_slice (
        .a    (a_q[int'(cnt)*SLICE +: SLICE]),
        .b    (b_q[int'(cnt)*SLICE +: SLICE]),
        .cin  (carry_q),
        .s    (s),
        .cout (cout),
        .cmsb (cmsb)
    );

    always_comb begin
        nxt_sum = sum_q;
        nxt_sum[int'(cnt)*SLICE +: SLICE] = s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            flags_q <= '0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    a_q     <= bus_a_i;
                    b_q     <= sub_en ? ~bus_b_i : bus_b_i;
                    carry_q <= sub_en | carry_i;
                    cnt     <= '0;
                    sum_q   <= '0;
                    state   <= BUSY;
                end
                BUSY: begin
                    sum_q   <= nxt_sum;
                    carry_q <= cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(NSLICE - 1)) begin
                        flags_q <= '{c: cout, v: cmsb ^ cout, z: nxt_sum == '0, n: nxt_sum[WIDTH-1]};
                        state   <= DONE;
                    end
                end
                DONE: if (ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready_o = state == IDLE;
    assign valid_o = state == DONE;
    assign bus_o   = valid_o ? sum_q : '0;
    assign {flag_c_o, flag_v_o, flag_z_o, flag_n_o} = valid_o ? flags_q : 4'b0;
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: directed self-checking bench for multicycle_adder (WIDTH=32, SLICE=8).
module tb_multicycle_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0, ready_i = 1'b0, carry_i = 1'b0, op_sub_i = 1'b0;
    logic [31:0] bus_a_i = '0, bus_b_i = '0;
    logic        ready_o, valid_o, flag_c_o, flag_v_o, flag_z_o, flag_n_o;
    logic [31:0] bus_o;
    int          checks = 0, errors = 0;

    multicycle_adder #(.WIDTH(32), .SLICE(8)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
        .bus_a_i(bus_a_i), .bus_b_i(bus_b_i), .carry_i(carry_i), .op_sub_i(op_sub_i),
        .valid_o(valid_o), .ready_i(ready_i), .bus_o(bus_o),
        .flag_c_o(flag_c_o), .flag_v_o(flag_v_o), .flag_z_o(flag_z_o), .flag_n_o(flag_n_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {flag_c_o, flag_v_o, flag_z_o, flag_n_o};
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sub);
        @(negedge clk);
        bus_a_i = a; bus_b_i = b; carry_i = c; op_sub_i = sub; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!valid_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic release_result();
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (bus_o !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h expected 00000000", bus_o); end
        checks++; if (flags() !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags()); end
    endtask

    task automatic test_add(input string name, input logic [31:0] a, input logic [31:0] b, input logic c,
                            input logic sub, input logic [31:0] exp_sum, input logic [3:0] exp_flags);
        int cyc;
        issue(a, b, c, sub);
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL %s_busy_ready: got %b expected 0", name, ready_o); end
        wait_done(cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL %s_latency: got %0d expected 4", name, cyc); end
        checks++; if (bus_o !== exp_sum) begin errors++; $display("FAIL %s_sum: got %h expected %h", name, bus_o, exp_sum); end
        checks++; if (flags() !== exp_flags) begin errors++; $display("FAIL %s_flags(cvzn): got %b expected %b", name, flags(), exp_flags); end
        release_result();
    endtask

    task automatic test_sub();
`ifdef MULTICYCLE_ADDER_SUB_EN
        test_add("sub", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'b0001);
        test_add("sub_eq", 32'd9, 32'd9, 1'b0, 1'b1, 32'h0, 4'b1010);
`else
        test_add("sub_ignored", 32'd5, 32'd7, 1'b1, 1'b1, 32'h0000_000D, 4'b0000);
`endif
    endtask

    task automatic test_busy_ignore();
        int cyc;
        issue(32'd100, 32'd23, 1'b0, 1'b0);
        bus_a_i = 32'hDEAD_BEEF; bus_b_i = 32'h1234_5678; carry_i = 1'b1; valid_i = 1'b1;
        wait_done(cyc);
        valid_i = 1'b0;
        checks++; if (bus_o !== 32'd123) begin errors++; $display("FAIL busy_ignore_sum: got %h expected 0000007b", bus_o); end
        release_result();
    endtask

    task automatic test_done_hold();
        int cyc;
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        wait_done(cyc);
        bus_a_i = 32'h1; bus_b_i = 32'h1; valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus_o !== 32'h0 || flags() !== 4'b1010 || ready_o !== 1'b0 || valid_o !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d: got bus=%h flags=%b ready=%b valid=%b expected bus=00000000 flags=1010 ready=0 valid=1",
                         i, bus_o, flags(), ready_o, valid_o);
            end
        end
        valid_i = 1'b0;
        release_result();
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || bus_o !== 32'h0) begin
            errors++;
            $display("FAIL hold_release: got ready=%b valid=%b bus=%h expected ready=1 valid=0 bus=00000000", ready_o, valid_o, bus_o);
        end
    endtask

    task automatic test_reset_busy();
        int cyc;
        logic seen;
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL rst_busy_state: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= valid_o;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_busy_no_valid: got %b expected 0", seen); end
        test_add("after_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_add("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 4'b1010);
        test_add("ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 4'b0101);
        test_add("cin_chain", 32'h0000_00FF, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 4'b0000);
        test_add("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 4'b1110);
        test_sub();
        test_busy_ignore();
        test_done_hold();
        test_reset_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
